// File: rtl/ifid_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : ifid_pkg                                               |
// | Description : Shared types and constants for the IF/ID packet queue. |
// | Revision    : 1.0                                                    |
// +--------------------------------------------------------------------+
package ifid_pkg;

  localparam int          XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h00000013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] instr;
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] pc_plus_4;
  } fetch_pkt_t;

endpackage
`default_nettype wire

// File: rtl/fifo_ptr_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : fifo_ptr_ctrl                                          |
// | Description : Read/write pointers and occupancy for a 2^n FIFO.      |
// | Revision    : 1.0                                                    |
// +--------------------------------------------------------------------+
module fifo_ptr_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [$clog2(DEPTH)-1:0]   o_rd_ptr,
  output logic [$clog2(DEPTH)-1:0]   o_wr_ptr,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH+1);

  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_CW-1:0] r_count;

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_ff @(posedge CLK) begin
    if (!RST_N || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_ptr = r_rd_ptr;
  assign o_wr_ptr = r_wr_ptr;
  assign o_count  = r_count;
  assign o_full   = (r_count == c_CW'(DEPTH));
  assign o_empty  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ifid_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : ifid_queue                                             |
// | Description : DEPTH-entry fetch-to-decode packet FIFO, NOP when empty.|
// | Revision    : 1.0                                                    |
// +--------------------------------------------------------------------+
module ifid_queue
  import ifid_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEFAULT,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(ifid_pkg::NOP_INSTR)
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       Flush_D,
  input  logic                       Valid_F,
  input  logic [XLEN-1:0]            Instr_F,
  input  logic [XLEN-1:0]            PC_F,
  input  logic [XLEN-1:0]            PC_Plus_4_F,
  output logic                       Ready_F,
  output logic                       Valid_D,
  input  logic                       Ready_D,
  output logic [XLEN-1:0]            Instr_D,
  output logic [XLEN-1:0]            PC_D,
  output logic [XLEN-1:0]            PC_Plus_4_D,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  localparam int c_AW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_4;
  } slot_t;

  slot_t           r_mem [DEPTH];
  logic [c_AW-1:0] w_rd_ptr;
  logic [c_AW-1:0] w_wr_ptr;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;

  // Ready_F ignores a same-cycle pop: a full queue never reuses a slot in one cycle.
  assign Ready_F = !w_full;
  assign Valid_D = !w_empty;
  assign w_push  = Valid_F && Ready_F;
  assign w_pop   = Valid_D && Ready_D;

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_flush  (Flush_D),
    .o_rd_ptr (w_rd_ptr),
    .o_wr_ptr (w_wr_ptr),
    .o_count  (Count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i].instr <= NOP_INSTR;
      end
    end else if (w_push && !Flush_D) begin
      r_mem[w_wr_ptr] <= '{instr: Instr_F, pc: PC_F, pc_plus_4: PC_Plus_4_F};
    end
  end

  always_comb begin
    Instr_D     = NOP_INSTR;
    PC_D        = '0;
    PC_Plus_4_D = '0;
    if (!w_empty) begin
      Instr_D     = r_mem[w_rd_ptr].instr;
      PC_D        = r_mem[w_rd_ptr].pc;
      PC_Plus_4_D = r_mem[w_rd_ptr].pc_plus_4;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifid_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_ifid_queue                                          |
// | Description : Directed and random checks of ifid_queue vs a queue.   |
// | Revision    : 1.0                                                    |
// +--------------------------------------------------------------------+
module tb_ifid_queue;
  import ifid_pkg::*;

  localparam int          DEPTH = 4;
  localparam int          CW    = $clog2(DEPTH+1);
  localparam logic [31:0] NOP   = 32'h00000013;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          Flush_D = 1'b0;
  logic          Valid_F = 1'b0;
  logic [31:0]   Instr_F = '0;
  logic [31:0]   PC_F = '0;
  logic [31:0]   PC_Plus_4_F = '0;
  logic          Ready_F;
  logic          Valid_D;
  logic          Ready_D = 1'b0;
  logic [31:0]   Instr_D;
  logic [31:0]   PC_D;
  logic [31:0]   PC_Plus_4_D;
  logic [CW-1:0] Count;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_pkt_t mq[$];

  ifid_queue #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .Flush_D     (Flush_D),
    .Valid_F     (Valid_F),
    .Instr_F     (Instr_F),
    .PC_F        (PC_F),
    .PC_Plus_4_F (PC_Plus_4_F),
    .Ready_F     (Ready_F),
    .Valid_D     (Valid_D),
    .Ready_D     (Ready_D),
    .Instr_D     (Instr_D),
    .PC_D        (PC_D),
    .PC_Plus_4_D (PC_Plus_4_D),
    .Count       (Count)
  );

  always #5 CLK = ~CLK;

  // Reference model: a plain FIFO of packets updated from the spec's rules.
  task automatic tick();
    bit acc, pp;
    if (!RST_N || Flush_D) begin
      mq.delete();
    end else begin
      acc = Valid_F && (mq.size() < DEPTH);
      pp  = Ready_D && (mq.size() > 0);
      if (pp)  void'(mq.pop_front());
      if (acc) mq.push_back('{instr: Instr_F, pc: PC_F, pc_plus_4: PC_Plus_4_F});
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_pkt(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    Valid_F     = v;
    Instr_F     = instr;
    PC_F        = pc;
    PC_Plus_4_F = pc + 32'd4;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    drive_pkt(1'b1, 32'hDEADBEEF, 32'h40);
    tick();
    tick();
    n_tests++; if (Count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", Count); end
    n_tests++; if (Valid_D !== 1'b0) begin n_fail++; $display("FAIL reset_valid_d: got %b expected 0", Valid_D); end
    n_tests++; if (Ready_F !== 1'b1) begin n_fail++; $display("FAIL reset_ready_f: got %b expected 1", Ready_F); end
    n_tests++; if (Instr_D !== NOP) begin n_fail++; $display("FAIL reset_instr_d: got %h expected %h", Instr_D, NOP); end
    n_tests++; if (PC_D !== 32'd0 || PC_Plus_4_D !== 32'd0) begin n_fail++; $display("FAIL reset_pc_d: got %h/%h expected 0/0", PC_D, PC_Plus_4_D); end
    RST_N = 1'b1;
    drive_pkt(1'b0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_fill_drain();
    logic [31:0] exp_pc;
    Ready_D = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_pkt(1'b1, $urandom, 32'h100 + 32'(4*i));
      tick();
      n_tests++; if (Count !== CW'(i+1)) begin n_fail++; $display("FAIL fill_count: got %0d expected %0d", Count, i+1); end
      n_tests++; if (PC_D !== 32'h100) begin n_fail++; $display("FAIL fill_stall_head: got %h expected 100", PC_D); end
    end
    n_tests++; if (Ready_F !== 1'b0) begin n_fail++; $display("FAIL full_ready_f: got %b expected 0", Ready_F); end
    drive_pkt(1'b1, $urandom, 32'h110);
    tick();
    n_tests++; if (Count !== 3'd4) begin n_fail++; $display("FAIL full_reject_count: got %0d expected 4", Count); end
    drive_pkt(1'b0, 32'd0, 32'd0);
    Ready_D = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'h100 + 32'(4*i);
      n_tests++; if (PC_D !== exp_pc || Valid_D !== 1'b1) begin n_fail++; $display("FAIL drain_pc: got %h v=%b expected %h v=1", PC_D, Valid_D, exp_pc); end
      tick();
    end
    n_tests++; if (Valid_D !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b expected 0", Valid_D); end
    Ready_D = 1'b0;
  endtask

  task automatic test_latency();
    drive_pkt(1'b1, 32'h00A00093, 32'h200);
    #1;
    n_tests++; if (Valid_D !== 1'b0 || Instr_D !== NOP) begin n_fail++; $display("FAIL latency_same_cycle: got v=%b %h expected v=0 %h", Valid_D, Instr_D, NOP); end
    tick();
    drive_pkt(1'b0, 32'd0, 32'd0);
    n_tests++; if (Valid_D !== 1'b1 || Instr_D !== 32'h00A00093) begin n_fail++; $display("FAIL latency_next: got v=%b %h expected v=1 00a00093", Valid_D, Instr_D); end
    n_tests++; if (PC_Plus_4_D !== 32'h204) begin n_fail++; $display("FAIL latency_pc4: got %h expected 204", PC_Plus_4_D); end
    Ready_D = 1'b1;
    tick();
    Ready_D = 1'b0;
    n_tests++; if (Count !== 3'd0) begin n_fail++; $display("FAIL latency_drain: got %0d expected 0", Count); end
  endtask

  task automatic test_wrap();
    Ready_D = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive_pkt(1'b1, $urandom, 32'(4*k));
      tick();
      n_tests++; if (Count !== 3'd1 || PC_D !== 32'(4*k)) begin n_fail++; $display("FAIL wrap_pkt%0d: got cnt=%0d pc=%h expected cnt=1 pc=%h", k, Count, PC_D, 4*k); end
    end
    drive_pkt(1'b0, 32'd0, 32'd0);
    tick();
    Ready_D = 1'b0;
    n_tests++; if (Count !== 3'd0) begin n_fail++; $display("FAIL wrap_final: got %0d expected 0", Count); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive_pkt(1'b1, $urandom, 32'h180 + 32'(4*i));
      tick();
    end
    n_tests++; if (Count !== 3'd3) begin n_fail++; $display("FAIL flush_pre: got %0d expected 3", Count); end
    Flush_D = 1'b1;
    Ready_D = 1'b1;
    drive_pkt(1'b1, 32'h12345678, 32'h400);
    tick();
    Flush_D = 1'b0;
    Ready_D = 1'b0;
    drive_pkt(1'b0, 32'd0, 32'd0);
    n_tests++; if (Count !== 3'd0 || Valid_D !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got cnt=%0d v=%b expected 0/0", Count, Valid_D); end
    n_tests++; if (Instr_D !== NOP) begin n_fail++; $display("FAIL flush_nop: got %h expected %h", Instr_D, NOP); end
    tick();
    n_tests++; if (Count !== 3'd0) begin n_fail++; $display("FAIL flush_pkt_absent: got %0d expected 0", Count); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      drive_pkt(1'b1, $urandom, 32'h280 + 32'(4*i));
      tick();
    end
    n_tests++; if (Count !== 3'd2) begin n_fail++; $display("FAIL rstmid_pre: got %0d expected 2", Count); end
    RST_N = 1'b0;
    drive_pkt(1'b1, $urandom, 32'h500);
    tick();
    RST_N = 1'b1;
    drive_pkt(1'b0, 32'd0, 32'd0);
    n_tests++; if (Count !== 3'd0 || Ready_F !== 1'b1 || Instr_D !== NOP) begin n_fail++; $display("FAIL rstmid_state: got cnt=%0d rdy=%b %h expected 0/1/%h", Count, Ready_F, Instr_D, NOP); end
    drive_pkt(1'b1, 32'h00100113, 32'h300);
    tick();
    drive_pkt(1'b0, 32'd0, 32'd0);
    n_tests++; if (Valid_D !== 1'b1 || PC_D !== 32'h300) begin n_fail++; $display("FAIL rstmid_head: got v=%b pc=%h expected v=1 pc=300", Valid_D, PC_D); end
    Ready_D = 1'b1;
    tick();
    Ready_D = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] e_instr, e_pc, e_pc4;
    for (int c = 0; c < 400; c++) begin
      drive_pkt($urandom_range(99) < 70, $urandom, $urandom);
      Ready_D = ($urandom_range(99) < 50);
      Flush_D = ($urandom_range(39) == 0);
      tick();
      Flush_D = 1'b0;
      e_instr = (mq.size() > 0) ? mq[0].instr : NOP;
      e_pc    = (mq.size() > 0) ? mq[0].pc : 32'd0;
      e_pc4   = (mq.size() > 0) ? mq[0].pc_plus_4 : 32'd0;
      n_tests++; if (Count !== CW'(mq.size())) begin n_fail++; $display("FAIL rand_count c%0d: got %0d expected %0d", c, Count, mq.size()); end
      n_tests++; if (Valid_D !== (mq.size() > 0) || Ready_F !== (mq.size() < DEPTH)) begin n_fail++; $display("FAIL rand_hs c%0d: got v=%b r=%b expected v=%b r=%b", c, Valid_D, Ready_F, mq.size() > 0, mq.size() < DEPTH); end
      n_tests++; if (Instr_D !== e_instr || PC_D !== e_pc || PC_Plus_4_D !== e_pc4) begin n_fail++; $display("FAIL rand_head c%0d: got %h/%h/%h expected %h/%h/%h", c, Instr_D, PC_D, PC_Plus_4_D, e_instr, e_pc, e_pc4); end
    end
    drive_pkt(1'b0, 32'd0, 32'd0);
    Ready_D = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_fill_drain();
    test_latency();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
